inventory_scheduler: RTL

Sequences a Gen2-style inventory round for the reader. It decides which command the TX path sends next (Query, QueryRep, ACK, QueryAdjust) and opens the RX reply window after each command. It classifies each slot as empty, single or collision, and adapts the slot-count exponent Q with the fixed-point Q-algorithm. It sits above the command/PIE TX chain and consumes reply-status pulses from the RX decode/CRC chain.

---
 rtl/inventory_scheduler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/inventory_scheduler.sv
// Purpose: sequences a Gen2-style inventory round (Query/QueryRep/ACK/QueryAdjust),
//          opens the RX reply window, classifies slots and adapts Q (4.4 fixed-point Q-algorithm).
// Latency/backpressure: start -> cmd_vld next cycle; cmd_vld holds until cmd_rdy (only stop drops it);
//          tx_done -> rx_en next cycle; reply -> rx_en low next cycle; T2_CYCLES gap before the next cmd_vld.
// Ports: clk/rst (sync, active-high); start/stop control; cmd_vld/cmd_type/cmd_q/cmd_rdy command handshake;
//        tx_done from TX; rx_en window; reply_vld/reply_err/epc_vld from RX; busy/done/slot_cnt/tag_cnt status.
module inventory_scheduler #(
    parameter int Q_INIT     = 4,
    parameter int C_STEP     = 5,
    parameter int RX_TIMEOUT = 400,
    parameter int T2_CYCLES  = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic        cmd_vld,
    output logic [1:0]  cmd_type,
    output logic [3:0]  cmd_q,
    input  logic        cmd_rdy,
    input  logic        tx_done,
    output logic        rx_en,
    input  logic        reply_vld,
    input  logic        reply_err,
    input  logic        epc_vld,
    output logic        busy,
    output logic        done,
    output logic [15:0] slot_cnt,
    output logic [15:0] tag_cnt
);

    localparam logic [1:0] CMD_QUERY    = 2'd0;
    localparam logic [1:0] CMD_QUERYREP = 2'd1;
    localparam logic [1:0] CMD_ACK      = 2'd2;
    localparam logic [1:0] CMD_QUERYADJ = 2'd3;

    localparam logic [7:0]  QFP_INIT = 8'(Q_INIT * 16);
    localparam logic [7:0]  QFP_MAX  = 8'd240;
    localparam logic [8:0]  STEP9    = 9'(C_STEP);
    localparam logic [15:0] RX_LOAD  = 16'(RX_TIMEOUT);
    localparam logic [15:0] GAP_LOAD = 16'(T2_CYCLES);

    // The decision step between GAP and ISSUE has no state of its own:
    // it is evaluated on the last GAP cycle so cmd_vld rises right after GAP.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_TX,
        S_RX,
        S_GAP
    } state_t;

    state_t      state;
    logic [7:0]  qfp;          // Q in 4.4 fixed point, clamped to 0..240
    logic [15:0] round_slot;   // slots opened in the current round
    logic        seen;         // any reply (single or collision) in this round
    logic        pend_ack;     // single reply captured; next command is ACK
    logic [15:0] rx_cnt;
    logic [15:0] gap_cnt;

    // Q-algorithm arithmetic
    logic [8:0]  qfp_plus_half;
    logic [3:0]  q_next;
    logic [8:0]  qfp_up;
    logic [7:0]  qfp_inc;
    logic [7:0]  qfp_dec;
    logic [15:0] round_len;
    logic        round_end;

    // RX window qualification
    logic rx_vld, rx_err, rx_epc, rx_timeout, rx_close, is_ack;

    always_comb begin
        qfp_plus_half = {1'b0, qfp} + 9'd8;
        q_next        = (qfp_plus_half[8:4] > 5'd15) ? 4'd15 : qfp_plus_half[7:4];
        qfp_up        = {1'b0, qfp} + STEP9;
        qfp_inc       = (qfp_up > {1'b0, QFP_MAX}) ? QFP_MAX : qfp_up[7:0];
        qfp_dec       = ({1'b0, qfp} < STEP9) ? 8'd0 : 8'(({1'b0, qfp} - STEP9));
        round_len     = 16'd1 << cmd_q;
        round_end     = (round_slot == round_len);

        is_ack     = (cmd_type == CMD_ACK);
        rx_vld     = rx_en & reply_vld;
        rx_err     = rx_en & reply_err;
        rx_epc     = rx_en & epc_vld;
        rx_timeout = rx_en & (rx_cnt == 16'd1);
        // epc_vld only terminates the window that follows an ACK
        rx_close   = rx_vld | rx_err | rx_timeout | (is_ack & rx_epc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cmd_vld    <= 1'b0;
            cmd_type   <= CMD_QUERY;
            cmd_q      <= 4'(Q_INIT);
            rx_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            slot_cnt   <= 16'd0;
            tag_cnt    <= 16'd0;
            qfp        <= QFP_INIT;
            round_slot <= 16'd0;
            seen       <= 1'b0;
            pend_ack   <= 1'b0;
            rx_cnt     <= 16'd0;
            gap_cnt    <= 16'd0;
        end else if (stop) begin
            // Abort from any state; counters deliberately kept for readout.
            state    <= S_IDLE;
            cmd_vld  <= 1'b0;
            rx_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pend_ack <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy stays high through the done cycle, so a start
                    // coinciding with done is ignored.
                    busy <= 1'b0;
                    if (start && !busy) begin
                        busy       <= 1'b1;
                        slot_cnt   <= 16'd0;
                        tag_cnt    <= 16'd0;
                        qfp        <= QFP_INIT;
                        cmd_q      <= 4'(Q_INIT);
                        round_slot <= 16'd0;
                        seen       <= 1'b0;
                        pend_ack   <= 1'b0;
                        cmd_type   <= CMD_QUERY;
                        cmd_vld    <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (cmd_rdy) begin
                        cmd_vld <= 1'b0;
                        state   <= S_WAIT_TX;
                        if (!is_ack) begin
                            if (slot_cnt != 16'hFFFF) slot_cnt <= slot_cnt + 16'd1;
                            if (cmd_type == CMD_QUERYREP) begin
                                round_slot <= round_slot + 16'd1;
                            end else begin
                                // QUERY/QUERYADJ start a new round with this slot
                                round_slot <= 16'd1;
                                seen       <= 1'b0;
                            end
                        end
                    end
                end

                S_WAIT_TX: begin
                    if (tx_done) begin
                        rx_en  <= 1'b1;
                        rx_cnt <= RX_LOAD;
                        state  <= S_RX;
                    end
                end

                S_RX: begin
                    if (is_ack) begin
                        if (rx_epc && tag_cnt != 16'hFFFF) tag_cnt <= tag_cnt + 16'd1;
                    end else if (rx_err) begin
                        // collision, including err+vld together
                        qfp  <= qfp_inc;
                        seen <= 1'b1;
                    end else if (rx_vld) begin
                        seen     <= 1'b1;
                        pend_ack <= 1'b1;
                    end else if (rx_timeout) begin
                        qfp <= qfp_dec;
                    end

                    if (rx_close) begin
                        rx_en   <= 1'b0;
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end

                S_GAP: begin
                    if (gap_cnt <= 16'd1) begin
                        if (pend_ack) begin
                            pend_ack <= 1'b0;
                            cmd_type <= CMD_ACK;
                            cmd_vld  <= 1'b1;
                            state    <= S_ISSUE;
                        end else if (round_end && !seen) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            cmd_vld <= 1'b1;
                            state   <= S_ISSUE;
                            if (round_end) begin
                                cmd_type <= CMD_QUERY;
                                cmd_q    <= q_next;
                            end else if (q_next != cmd_q) begin
                                cmd_type <= CMD_QUERYADJ;
                                cmd_q    <= q_next;
                            end else begin
                                cmd_type <= CMD_QUERYREP;
                            end
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
